// File: rtl/ysyx_25020032_axi_rd_slave_pkg.sv
// Shared AXI read-slave definitions: response and burst encodings, default
// transaction field values, the responder FSM state type and a helper that
// gives the low-address alignment mask for a given AxSIZE.
package ysyx_25020032_axi_rd_slave_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [3:0] DEF_ID   = 4'd0;
    localparam logic [7:0] DEF_LEN  = 8'd0;
    localparam logic [2:0] DEF_SIZE = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_MEM   = 2'd2,
        ST_RESP  = 2'd3
    } rd_state_e;

    // Address bits that must be zero for a beat of 1<<size bytes.
    function automatic logic [31:0] size_mask(input logic [2:0] size);
        logic [31:0] mask;
        case (size)
            3'd0:    mask = 32'h0000_0000;
            3'd1:    mask = 32'h0000_0001;
            3'd2:    mask = 32'h0000_0003;
            default: mask = 32'h0000_0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/ysyx_25020032_axi_addr_gen.sv
// Per-beat address helper for the AXI read slave (purely combinational).
// Ports:
//   addr      in   byte address of the current beat
//   size      in   AxSIZE (log2 bytes per beat)
//   burst     in   AxBURST encoding
//   next_addr out  address of the following beat
//   resp      out  RRESP this beat will carry (SLVERR > DECERR > OKAY priority)
//   word_addr out  storage word address, (addr-BASE)>>2
module ysyx_25020032_axi_addr_gen
    import ysyx_25020032_axi_rd_slave_pkg::*;
#(
    parameter logic [31:0] BASE   = 32'h2000_0000,
    parameter int          MEM_AW = 16
) (
    input  logic [31:0]       addr,
    input  logic [2:0]        size,
    input  logic [1:0]        burst,
    output logic [31:0]       next_addr,
    output logic [1:0]        resp,
    output logic [MEM_AW-1:0] word_addr
);

    // Window size held in 33 bits so a full 4 GiB window still compares correctly.
    localparam logic [32:0] WIN_BYTES = 33'd4 << MEM_AW;

    logic [31:0] offset_s;

    assign offset_s  = addr - BASE;
    assign word_addr = offset_s[MEM_AW+1:2];

    // Response classification; addresses below BASE wrap to huge offsets and fall out as DECERR.
    always_comb begin
        resp = RESP_OKAY;
        if ((burst == BURST_WRAP) || (burst == 2'b11)) begin
            resp = RESP_SLVERR;
        end else if (size > 3'd2) begin
            resp = RESP_SLVERR;
        end else if ((addr & size_mask(size)) != 32'h0000_0000) begin
            resp = RESP_SLVERR;
        end else if ({1'b0, offset_s} >= WIN_BYTES) begin
            resp = RESP_DECERR;
        end else begin
            resp = RESP_OKAY;
        end
    end

    // Next-beat address; unsupported burst types are all-error so they simply hold.
    always_comb begin
        next_addr = addr;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_INCR:  next_addr = addr + (32'd1 << size);
            default:     next_addr = addr;
        endcase
    end

endmodule

// File: rtl/ysyx_25020032_axi_rd_slave.sv
// AXI4 read responder (AR + R) in front of a synchronous word-addressed store.
// One burst at a time; LATENCY idle cycles precede every storage access.
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   arvalid/arready/araddr/arid/arlen/arsize/arburst   AR channel
//   rvalid/rready/rdata/rresp/rlast/rid                 R channel
//   mem_ren/mem_addr/mem_rdata     storage port; data arrives the cycle after
//                                  mem_ren and is held until the next mem_ren
module ysyx_25020032_axi_rd_slave
    import ysyx_25020032_axi_rd_slave_pkg::*;
#(
    parameter logic [31:0] BASE    = 32'h2000_0000,
    parameter int          MEM_AW  = 16,
    parameter int          LATENCY = 1,
    parameter int          ID_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arvalid,
    output logic              arready,
    input  logic [31:0]       araddr,
    input  logic [ID_W-1:0]   arid,
    input  logic [7:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    output logic              rvalid,
    input  logic              rready,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic [ID_W-1:0]   rid,
    output logic              mem_ren,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [31:0]       mem_rdata
);

    localparam int DLY_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'((LATENCY > 0) ? (LATENCY - 1) : 0);
    // State entered whenever a new beat's address is ready.
    localparam rd_state_e ST_BEAT = (LATENCY > 0) ? ST_DELAY : ST_MEM;

    rd_state_e         state_r, state_n;
    logic [31:0]       addr_r, addr_n;
    logic [ID_W-1:0]   id_r, id_n;
    logic [7:0]        len_r, len_n;
    logic [2:0]        size_r, size_n;
    logic [1:0]        burst_r, burst_n;
    logic [7:0]        beat_r, beat_n;
    logic [DLY_W-1:0]  dly_r, dly_n;
    logic              arready_r, arready_n;
    logic              rvalid_r, rvalid_n;
    logic [1:0]        rresp_r, rresp_n;
    logic              rlast_r, rlast_n;
    logic              data_ok_r, data_ok_n;

    logic [31:0]       next_addr_s;
    logic [1:0]        resp_s;
    logic [MEM_AW-1:0] word_s;

    ysyx_25020032_axi_addr_gen #(
        .BASE   (BASE),
        .MEM_AW (MEM_AW)
    ) u_addr_gen (
        .addr      (addr_r),
        .size      (size_r),
        .burst     (burst_r),
        .next_addr (next_addr_s),
        .resp      (resp_s),
        .word_addr (word_s)
    );

    // State, burst context and registered R-channel outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            addr_r    <= 32'h0000_0000;
            id_r      <= ID_W'(DEF_ID);
            len_r     <= DEF_LEN;
            size_r    <= DEF_SIZE;
            burst_r   <= BURST_INCR;
            beat_r    <= 8'd0;
            dly_r     <= '0;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rresp_r   <= RESP_OKAY;
            rlast_r   <= 1'b0;
            data_ok_r <= 1'b0;
        end else begin
            state_r   <= state_n;
            addr_r    <= addr_n;
            id_r      <= id_n;
            len_r     <= len_n;
            size_r    <= size_n;
            burst_r   <= burst_n;
            beat_r    <= beat_n;
            dly_r     <= dly_n;
            arready_r <= arready_n;
            rvalid_r  <= rvalid_n;
            rresp_r   <= rresp_n;
            rlast_r   <= rlast_n;
            data_ok_r <= data_ok_n;
        end
    end

    // Next-state and next-register computation for the burst FSM.
    always_comb begin
        state_n   = state_r;
        addr_n    = addr_r;
        id_n      = id_r;
        len_n     = len_r;
        size_n    = size_r;
        burst_n   = burst_r;
        beat_n    = beat_r;
        dly_n     = dly_r;
        arready_n = arready_r;
        rvalid_n  = rvalid_r;
        rresp_n   = rresp_r;
        rlast_n   = rlast_r;
        data_ok_n = data_ok_r;
        case (state_r)
            ST_IDLE: begin
                if (arvalid && arready_r) begin
                    addr_n    = araddr;
                    id_n      = arid;
                    len_n     = arlen;
                    size_n    = arsize;
                    burst_n   = arburst;
                    beat_n    = 8'd0;
                    dly_n     = '0;
                    arready_n = 1'b0;
                    state_n   = ST_BEAT;
                end else begin
                    // Also raises arready in the first cycle out of reset.
                    arready_n = 1'b1;
                end
            end
            ST_DELAY: begin
                if (dly_r == DLY_LAST) begin
                    state_n = ST_MEM;
                end else begin
                    dly_n = dly_r + 1'b1;
                end
            end
            ST_MEM: begin
                // addr_r already holds this beat's address, so the response is final here.
                state_n   = ST_RESP;
                rvalid_n  = 1'b1;
                rresp_n   = resp_s;
                rlast_n   = (beat_r == len_r);
                data_ok_n = (resp_s == RESP_OKAY);
            end
            ST_RESP: begin
                if (rready) begin
                    rvalid_n  = 1'b0;
                    rlast_n   = 1'b0;
                    rresp_n   = RESP_OKAY;
                    data_ok_n = 1'b0;
                    if (rlast_r) begin
                        state_n   = ST_IDLE;
                        arready_n = 1'b1;
                    end else begin
                        beat_n  = beat_r + 8'd1;
                        addr_n  = next_addr_s;
                        dly_n   = '0;
                        state_n = ST_BEAT;
                    end
                end else begin
                    rvalid_n = 1'b1;
                end
            end
            default: begin
                state_n   = ST_IDLE;
                arready_n = 1'b0;
                rvalid_n  = 1'b0;
            end
        endcase
    end

    // The store holds its data until the next strobe, and no strobe is issued
    // while a beat waits in RESP, so rdata can pass mem_rdata straight through
    // and still stays stable under backpressure.
    assign rdata    = (rvalid_r && data_ok_r) ? mem_rdata : 32'h0000_0000;
    assign mem_ren  = (state_r == ST_MEM) && (resp_s == RESP_OKAY);
    assign mem_addr = mem_ren ? word_s : '0;
    assign arready  = arready_r;
    assign rvalid   = rvalid_r;
    assign rresp    = rresp_r;
    assign rlast    = rlast_r;
    assign rid      = id_r;

endmodule

// File: tb/tb_ysyx_25020032_axi_rd_slave.sv
// Directed bench for the AXI read slave: a table of bursts with hand-computed
// per-beat responses and storage word addresses, plus reset sequences.
module tb_ysyx_25020032_axi_rd_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [3:0]  rid;
    logic        mem_ren;
    logic [3:0]  mem_addr;
    logic [31:0] mem_rdata = 32'h0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ysyx_25020032_axi_rd_slave #(
        .BASE    (32'h2000_0000),
        .MEM_AW  (4),
        .LATENCY (1),
        .ID_W    (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .arvalid   (arvalid),
        .arready   (arready),
        .araddr    (araddr),
        .arid      (arid),
        .arlen     (arlen),
        .arsize    (arsize),
        .arburst   (arburst),
        .rvalid    (rvalid),
        .rready    (rready),
        .rdata     (rdata),
        .rresp     (rresp),
        .rlast     (rlast),
        .rid       (rid),
        .mem_ren   (mem_ren),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata)
    );

    // Storage model: 16 words, one-cycle read, data held between strobes.
    logic [31:0] mem [16];
    always @(posedge clk) begin
        if (mem_ren) mem_rdata <= mem[mem_addr];
    end

    int         ren_total = 0;
    logic [3:0] ren_addr  = 4'd0;
    always @(negedge clk) begin
        if (mem_ren) begin
            ren_total <= ren_total + 1;
            ren_addr  <= mem_addr;
        end
    end

    typedef struct {
        logic [31:0]      addr;
        logic [3:0]       id;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        logic             early;
        logic [7:0]       stall;
        logic [3:0][1:0]  resp;
        logic [3:0][3:0]  word;
    } vec_t;

    localparam int NV = 12;
    vec_t vec [NV];

    task automatic set_vec(input int i, input logic [31:0] a, input logic [3:0] id,
                           input logic [7:0] len, input logic [2:0] sz, input logic [1:0] bu,
                           input logic early, input logic [7:0] stall,
                           input logic [1:0] r0, input logic [1:0] r1,
                           input logic [1:0] r2, input logic [1:0] r3,
                           input logic [3:0] w0, input logic [3:0] w1,
                           input logic [3:0] w2, input logic [3:0] w3);
        vec[i].addr  = a;
        vec[i].id    = id;
        vec[i].len   = len;
        vec[i].size  = sz;
        vec[i].burst = bu;
        vec[i].early = early;
        vec[i].stall = stall;
        vec[i].resp  = {r3, r2, r1, r0};
        vec[i].word  = {w3, w2, w1, w0};
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Wait (bounded) for arready, then present one AR request; returns after the handshake edge + 1.
    task automatic issue_ar(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                            input logic [2:0] sz, input logic [1:0] bu, output logic ok);
        int k = 0;
        @(negedge clk);
        while (!arready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("ar_ready_wait", {31'd0, arready}, 32'd1);
        ok = arready;
        if (ok) begin
            araddr  = a;
            arid    = id;
            arlen   = len;
            arsize  = sz;
            arburst = bu;
            arvalid = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    // Count negedges until rvalid (bounded); returns 0 on timeout.
    task automatic wait_rvalid(output int lat);
        lat = 0;
        for (int t = 1; t <= 20; t++) begin
            @(negedge clk);
            arvalid = 1'b0;
            if (rvalid) begin
                lat = t;
                break;
            end
        end
    endtask

    task automatic run_burst(input int i);
        logic        ok;
        int          lat;
        int          snap;
        logic [1:0]  er;
        logic [31:0] ed;
        issue_ar(vec[i].addr, vec[i].id, vec[i].len, vec[i].size, vec[i].burst, ok);
        if (!ok) return;
        rready = vec[i].early;
        snap   = ren_total;
        for (int b = 0; b <= int'(vec[i].len); b++) begin
            wait_rvalid(lat);
            chk($sformatf("v%0d.b%0d.latency", i, b), 32'(lat), 32'd3);
            if (lat == 0) return;
            er = vec[i].resp[b];
            ed = (er == 2'b00) ? mem[vec[i].word[b]] : 32'h0;
            chk($sformatf("v%0d.b%0d.rresp", i, b), {30'd0, rresp}, {30'd0, er});
            chk($sformatf("v%0d.b%0d.rdata", i, b), rdata, ed);
            chk($sformatf("v%0d.b%0d.rlast", i, b), {31'd0, rlast}, (b == int'(vec[i].len)) ? 32'd1 : 32'd0);
            chk($sformatf("v%0d.b%0d.rid", i, b), {28'd0, rid}, {28'd0, vec[i].id});
            chk($sformatf("v%0d.b%0d.ren_count", i, b), 32'(ren_total - snap), (er == 2'b00) ? 32'd1 : 32'd0);
            if (er == 2'b00) chk($sformatf("v%0d.b%0d.mem_addr", i, b), {28'd0, ren_addr}, {28'd0, vec[i].word[b]});
            if (b == int'(vec[i].stall)) begin
                rready = 1'b0;
                repeat (2) begin
                    @(negedge clk);
                    chk($sformatf("v%0d.b%0d.stall_rvalid", i, b), {31'd0, rvalid}, 32'd1);
                    chk($sformatf("v%0d.b%0d.stall_rdata", i, b), rdata, ed);
                    chk($sformatf("v%0d.b%0d.stall_rresp", i, b), {30'd0, rresp}, {30'd0, er});
                    chk($sformatf("v%0d.b%0d.stall_rlast", i, b), {31'd0, rlast}, (b == int'(vec[i].len)) ? 32'd1 : 32'd0);
                end
            end
            rready = 1'b1;
            @(posedge clk);
            #1;
            rready = vec[i].early;
            snap   = ren_total;
        end
        @(negedge clk);
        chk($sformatf("v%0d.arready_back", i), {31'd0, arready}, 32'd1);
        chk($sformatf("v%0d.rvalid_low", i), {31'd0, rvalid}, 32'd0);
        rready = 1'b0;
    endtask

    initial begin
        logic ok;
        int   lat;
        for (int i = 0; i < 16; i++) mem[i] = 32'hC0DE_0000 + 32'(i);
        mem[2] = 32'hDEAD_BEEF;

        //         idx addr           id    len   sz    burst early stall  r0     r1     r2     r3     w0     w1     w2     w3
        set_vec(0,  32'h2000_0008, 4'd5, 8'd0, 3'd2, 2'b01, 1'b0, 8'hFF, 2'b00, 2'b00, 2'b00, 2'b00, 4'd2,  4'd0,  4'd0,  4'd0);
        set_vec(1,  32'h2000_0010, 4'd3, 8'd3, 3'd2, 2'b01, 1'b0, 8'd1,  2'b00, 2'b00, 2'b00, 2'b00, 4'd4,  4'd5,  4'd6,  4'd7);
        set_vec(2,  32'h2000_0004, 4'd9, 8'd2, 3'd2, 2'b00, 1'b1, 8'hFF, 2'b00, 2'b00, 2'b00, 2'b00, 4'd1,  4'd1,  4'd1,  4'd0);
        set_vec(3,  32'h1FFF_FFFC, 4'd1, 8'd0, 3'd2, 2'b01, 1'b0, 8'hFF, 2'b11, 2'b00, 2'b00, 2'b00, 4'd0,  4'd0,  4'd0,  4'd0);
        set_vec(4,  32'h2000_0002, 4'd2, 8'd0, 3'd2, 2'b01, 1'b0, 8'hFF, 2'b10, 2'b00, 2'b00, 2'b00, 4'd0,  4'd0,  4'd0,  4'd0);
        set_vec(5,  32'h2000_0000, 4'd6, 8'd2, 3'd2, 2'b10, 1'b0, 8'hFF, 2'b10, 2'b10, 2'b10, 2'b00, 4'd0,  4'd0,  4'd0,  4'd0);
        set_vec(6,  32'h2000_003C, 4'd7, 8'd1, 3'd2, 2'b01, 1'b1, 8'hFF, 2'b00, 2'b11, 2'b00, 2'b00, 4'd15, 4'd0,  4'd0,  4'd0);
        set_vec(7,  32'h2000_0000, 4'd4, 8'd0, 3'd3, 2'b01, 1'b0, 8'hFF, 2'b10, 2'b00, 2'b00, 2'b00, 4'd0,  4'd0,  4'd0,  4'd0);
        set_vec(8,  32'h2000_0006, 4'hA, 8'd1, 3'd1, 2'b01, 1'b0, 8'd0,  2'b00, 2'b00, 2'b00, 2'b00, 4'd1,  4'd2,  4'd0,  4'd0);
        set_vec(9,  32'h2000_0003, 4'hB, 8'd1, 3'd0, 2'b01, 1'b0, 8'hFF, 2'b00, 2'b00, 2'b00, 2'b00, 4'd0,  4'd1,  4'd0,  4'd0);
        set_vec(10, 32'h2000_0000, 4'hC, 8'd1, 3'd2, 2'b11, 1'b0, 8'hFF, 2'b10, 2'b10, 2'b00, 2'b00, 4'd0,  4'd0,  4'd0,  4'd0);
        set_vec(11, 32'h1FFF_FFFE, 4'hD, 8'd0, 3'd2, 2'b01, 1'b0, 8'hFF, 2'b10, 2'b00, 2'b00, 2'b00, 4'd0,  4'd0,  4'd0,  4'd0);

        rst = 1'b0; arvalid = 1'b0; rready = 1'b0;
        araddr = 32'h0; arid = 4'd0; arlen = 8'd0; arsize = 3'd0; arburst = 2'b00;

        // Reset state.
        #12;
        chk("rst.arready", {31'd0, arready}, 32'd0);
        chk("rst.rvalid",  {31'd0, rvalid},  32'd0);
        chk("rst.rlast",   {31'd0, rlast},   32'd0);
        chk("rst.rresp",   {30'd0, rresp},   32'd0);
        chk("rst.rid",     {28'd0, rid},     32'd0);
        chk("rst.mem_ren", {31'd0, mem_ren}, 32'd0);
        chk("rst.rdata",   rdata,            32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst.arready_after_release", {31'd0, arready}, 32'd1);

        for (int i = 0; i < NV; i++) run_burst(i);

        // Reset in the middle of a 4-beat INCR burst, while beat 1 is being presented.
        issue_ar(32'h2000_0010, 4'd3, 8'd3, 3'd2, 2'b01, ok);
        if (ok) begin
            wait_rvalid(lat);
            chk("midrst.b0_latency", 32'(lat), 32'd3);
            rready = 1'b1;
            @(posedge clk);
            #1;
            rready = 1'b0;
            wait_rvalid(lat);
            chk("midrst.b1_latency", 32'(lat), 32'd3);
        end
        rst = 1'b0;
        #1;
        chk("midrst.rvalid",  {31'd0, rvalid},  32'd0);
        chk("midrst.arready", {31'd0, arready}, 32'd0);
        chk("midrst.rlast",   {31'd0, rlast},   32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst.arready_after_release", {31'd0, arready}, 32'd1);
        chk("midrst.no_stray_beat", {31'd0, rvalid}, 32'd0);
        run_burst(0);
        run_burst(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
